// File: rtl/mem_port_arbiter_if.sv
// Bundle between two memory requesters, the arbiter and a combinational-read data memory.
// Requesters hold req/we/addr/wdata until ack; the memory answers mem_rdata in the same cycle.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  p0_req;
  logic                  p0_we;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_ack;
  logic [DATA_WIDTH-1:0] p0_rdata;

  logic                  p1_req;
  logic                  p1_we;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_ack;
  logic [DATA_WIDTH-1:0] p1_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;
  logic                  grant;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re, busy, grant
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_ack, p0_rdata, p1_ack, p1_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re, busy, grant
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter (IDLE->ACCESS->DONE); ARB_ROUND_ROBIN_EN selects round-robin over fixed p0 priority.
// Ack 2 cycles after req is sampled in IDLE, one access per 3 cycles; requesters hold req until ack.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                stateQ;
  logic                  grantQ;
  logic                  busyQ;
  logic                  ack0Q;
  logic                  ack1Q;
  logic                  memWeQ;
  logic                  memReQ;
  logic [ADDR_WIDTH-1:0] memAddrQ;
  logic [DATA_WIDTH-1:0] memWdataQ;
  logic [DATA_WIDTH-1:0] rdata0Q;
  logic [DATA_WIDTH-1:0] rdata1Q;
`ifdef ARB_ROUND_ROBIN_EN
  logic                  lastServedQ;
`endif

  logic                  winIdx;
  logic                  selWe;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selWdata;

  always_comb begin
    winIdx = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    // On contention the port not served last wins; otherwise whoever is asking.
    if (bus.p0_req && bus.p1_req) winIdx = ~lastServedQ;
    else                          winIdx = bus.p1_req;
`else
    winIdx = ~bus.p0_req;
`endif
    selWe    = winIdx ? bus.p1_we    : bus.p0_we;
    selAddr  = winIdx ? bus.p1_addr  : bus.p0_addr;
    selWdata = winIdx ? bus.p1_wdata : bus.p0_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ      <= IDLE;
      grantQ      <= 1'b0;
      busyQ       <= 1'b0;
      ack0Q       <= 1'b0;
      ack1Q       <= 1'b0;
      memWeQ      <= 1'b0;
      memReQ      <= 1'b0;
      memAddrQ    <= '0;
      memWdataQ   <= '0;
      rdata0Q     <= '0;
      rdata1Q     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      lastServedQ <= 1'b0;
`endif
    end else begin
      ack0Q <= 1'b0;
      ack1Q <= 1'b0;
      case (stateQ)
        IDLE: begin
          if (bus.p0_req || bus.p1_req) begin
            stateQ    <= ACCESS;
            busyQ     <= 1'b1;
            grantQ    <= winIdx;
            memAddrQ  <= selAddr;
            memWdataQ <= selWdata;
            memWeQ    <= selWe;
            memReQ    <= ~selWe;
`ifdef ARB_ROUND_ROBIN_EN
            lastServedQ <= winIdx;
`endif
          end
        end
        ACCESS: begin
          // Latched strobe type decides the capture; req may already be gone.
          if (memReQ) begin
            if (grantQ) rdata1Q <= bus.mem_rdata;
            else        rdata0Q <= bus.mem_rdata;
          end
          memWeQ <= 1'b0;
          memReQ <= 1'b0;
          ack0Q  <= ~grantQ;
          ack1Q  <= grantQ;
          stateQ <= DONE;
        end
        DONE: begin
          busyQ  <= 1'b0;
          stateQ <= IDLE;
        end
        default: begin
          busyQ  <= 1'b0;
          memWeQ <= 1'b0;
          memReQ <= 1'b0;
          stateQ <= IDLE;
        end
      endcase
    end
  end

  assign bus.p0_ack    = ack0Q;
  assign bus.p1_ack    = ack1Q;
  assign bus.p0_rdata  = rdata0Q;
  assign bus.p1_rdata  = rdata1Q;
  assign bus.mem_addr  = memAddrQ;
  assign bus.mem_wdata = memWdataQ;
  assign bus.mem_we    = memWeQ;
  assign bus.mem_re    = memReQ;
  assign bus.busy      = busyQ;
  assign bus.grant     = grantQ;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small word memory and a per-cycle protocol monitor.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  bit   monEn = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Unwritten words read back as 0xC0DE0000 | word index.
  bit        memValid [0:63];
  bit [31:0] memData  [0:63];
  logic [5:0] rdIdx;
  assign rdIdx = bus.mem_addr[7:2];
  assign bus.mem_rdata = memValid[rdIdx] ? memData[rdIdx] : (32'hC0DE_0000 | {26'd0, rdIdx});

  always @(posedge clk) begin
    if (bus.mem_we) begin
      memValid[bus.mem_addr[7:2]] <= 1'b1;
      memData[bus.mem_addr[7:2]]  <= bus.mem_wdata;
    end
  end

  // {busy, mem_we, mem_re, p0_ack, p1_ack}
  logic [4:0] st;
  assign st = {bus.busy, bus.mem_we, bus.mem_re, bus.p0_ack, bus.p1_ack};

  always @(negedge clk) begin
    if (monEn) begin
      checks++;
      if ((bus.p0_ack && bus.p1_ack) || (bus.mem_we && bus.mem_re) ||
          ((bus.mem_we || bus.mem_re) && (!bus.busy || bus.p0_ack || bus.p1_ack))) begin
        failures++;
        $display("FAIL monitor t=%0t got ack0=%b ack1=%b we=%b re=%b busy=%b, need exclusive acks/strobes and strobes only in ACCESS",
                 $time, bus.p0_ack, bus.p1_ack, bus.mem_we, bus.mem_re, bus.busy);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_wdata = '0;
    cyc(2);
    checks++;
    if (st !== 5'b00000 || bus.grant !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl got st=%b grant=%b need st=00000 grant=0", st, bus.grant);
    end
    checks++;
    if (bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0) begin
      failures++; $display("FAIL reset_membus got addr=%h wdata=%h need 0/0", bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if (bus.p0_rdata !== 32'd0 || bus.p1_rdata !== 32'd0) begin
      failures++; $display("FAIL reset_rdata got p0=%h p1=%h need 0/0", bus.p0_rdata, bus.p1_rdata);
    end
    reset = 1'b1;
    monEn = 1'b1;
    cyc(1);
    checks++;
    if (st !== 5'b00000) begin
      failures++; $display("FAIL idle_no_req got st=%b need 00000", st);
    end
  endtask

  task automatic test_write_read();
    bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 32'h10; bus.p0_wdata = 32'hDEAD_BEEF;
    cyc(1);
    checks++;
    if (st !== 5'b11000 || bus.grant !== 1'b0) begin
      failures++; $display("FAIL wr_access got st=%b grant=%b need st=11000 grant=0", st, bus.grant);
    end
    checks++;
    if (bus.mem_addr !== 32'h10 || bus.mem_wdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL wr_bus got addr=%h wdata=%h need 00000010/deadbeef", bus.mem_addr, bus.mem_wdata);
    end
    cyc(1);
    checks++;
    if (st !== 5'b10010) begin
      failures++; $display("FAIL wr_ack got st=%b need 10010", st);
    end
    checks++;
    if (bus.p0_rdata !== 32'd0) begin
      failures++; $display("FAIL wr_keeps_rdata got %h need 00000000", bus.p0_rdata);
    end
    bus.p0_req = 0; bus.p0_we = 0;
    cyc(1);
    checks++;
    if (st !== 5'b00000 || bus.mem_addr !== 32'h10) begin
      failures++; $display("FAIL wr_idle got st=%b addr=%h need 00000/00000010", st, bus.mem_addr);
    end
    bus.p0_req = 1;
    cyc(1);
    checks++;
    if (st !== 5'b10100) begin
      failures++; $display("FAIL rd_access got st=%b need 10100", st);
    end
    cyc(1);
    checks++;
    if (st !== 5'b10010 || bus.p0_rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL rd_ack got st=%b rdata=%h need 10010/deadbeef", st, bus.p0_rdata);
    end
    checks++;
    if (bus.p1_rdata !== 32'd0) begin
      failures++; $display("FAIL rd_other_port got p1_rdata=%h need 00000000", bus.p1_rdata);
    end
    bus.p0_req = 0;
    cyc(1);
  endtask

  task automatic test_early_drop();
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 32'h20;
    cyc(1);
    checks++;
    if (st !== 5'b10100 || bus.grant !== 1'b1) begin
      failures++; $display("FAIL drop_access got st=%b grant=%b need 10100/1", st, bus.grant);
    end
    bus.p1_req = 0;
    cyc(1);
    checks++;
    if (st !== 5'b10001 || bus.p1_rdata !== 32'hC0DE_0008) begin
      failures++; $display("FAIL drop_ack got st=%b rdata=%h need 10001/c0de0008", st, bus.p1_rdata);
    end
    checks++;
    if (bus.p0_rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL drop_p0_rdata got %h need deadbeef", bus.p0_rdata);
    end
    cyc(1);
    checks++;
    if (st !== 5'b00000) begin
      failures++; $display("FAIL drop_idle got st=%b need 00000", st);
    end
    cyc(1);
    checks++;
    if (st !== 5'b00000) begin
      failures++; $display("FAIL drop_stays_idle got st=%b need 00000", st);
    end
  endtask

  task automatic test_reset_mid_access();
    bus.p1_req = 1; bus.p1_we = 1; bus.p1_addr = 32'h30; bus.p1_wdata = 32'h1234_5678;
    cyc(1);
    checks++;
    if (st !== 5'b11000 || bus.grant !== 1'b1) begin
      failures++; $display("FAIL rst_mid_access got st=%b grant=%b need 11000/1", st, bus.grant);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (st !== 5'b00000 || bus.grant !== 1'b0) begin
      failures++; $display("FAIL rst_mid_async got st=%b grant=%b need 00000/0", st, bus.grant);
    end
    bus.p1_req = 0; bus.p1_we = 0;
    @(posedge clk);
    #1 reset = 1'b1;
    cyc(1);
    checks++;
    if (st !== 5'b00000 || bus.p1_rdata !== 32'd0) begin
      failures++; $display("FAIL rst_mid_release got st=%b p1_rdata=%h need 00000/00000000", st, bus.p1_rdata);
    end
    checks++;
    if (memValid[12] !== 1'b0) begin
      failures++; $display("FAIL rst_mid_no_write got written=%b need 0", memValid[12]);
    end
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  task automatic test_round_robin();
    bit expIdx [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int now = 0;
    int lastAck = -1;
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 32'h04;
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 32'h08;
    for (int k = 0; k < 4; k++) begin
      cyc(1); now++;
      checks++;
      if (st !== 5'b10100 || bus.grant !== expIdx[k]) begin
        failures++; $display("FAIL rr_grant_%0d got st=%b grant=%b need 10100/%b", k, st, bus.grant, expIdx[k]);
      end
      cyc(1); now++;
      checks++;
      if ({bus.p0_ack, bus.p1_ack} !== (expIdx[k] ? 2'b01 : 2'b10)) begin
        failures++; $display("FAIL rr_ack_%0d got ack0=%b ack1=%b need port %0d", k, bus.p0_ack, bus.p1_ack, expIdx[k]);
      end
      if (k > 0) begin
        checks++;
        if (now - lastAck !== 3) begin
          failures++; $display("FAIL rr_spacing_%0d got %0d need 3", k, now - lastAck);
        end
      end
      lastAck = now;
      if (k == 3) begin
        bus.p0_req = 0; bus.p1_req = 0;
      end
      cyc(1); now++;
    end
    checks++;
    if (bus.p0_rdata !== 32'hC0DE_0001 || bus.p1_rdata !== 32'hC0DE_0002) begin
      failures++; $display("FAIL rr_rdata got p0=%h p1=%h need c0de0001/c0de0002", bus.p0_rdata, bus.p1_rdata);
    end
  endtask
`else
  task automatic test_fixed_priority();
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 32'h04;
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 32'h08;
    for (int n = 0; n < 3; n++) begin
      cyc(1);
      checks++;
      if (st !== 5'b10100 || bus.grant !== 1'b0) begin
        failures++; $display("FAIL fp_grant_%0d got st=%b grant=%b need 10100/0", n, st, bus.grant);
      end
      cyc(1);
      checks++;
      if (st !== 5'b10010 || bus.p0_rdata !== 32'hC0DE_0001) begin
        failures++; $display("FAIL fp_ack_%0d got st=%b rdata=%h need 10010/c0de0001", n, st, bus.p0_rdata);
      end
      if (n == 2) bus.p0_req = 0;
      cyc(1);
      checks++;
      if (st !== 5'b00000) begin
        failures++; $display("FAIL fp_idle_%0d got st=%b need 00000", n, st);
      end
    end
    cyc(1);
    checks++;
    if (st !== 5'b10100 || bus.grant !== 1'b1) begin
      failures++; $display("FAIL fp_p1_grant got st=%b grant=%b need 10100/1", st, bus.grant);
    end
    cyc(1);
    checks++;
    if (st !== 5'b10001 || bus.p1_rdata !== 32'hC0DE_0002) begin
      failures++; $display("FAIL fp_p1_ack got st=%b rdata=%h need 10001/c0de0002", st, bus.p1_rdata);
    end
    bus.p1_req = 0;
    cyc(1);
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_early_drop();
    test_reset_mid_access();
`ifdef ARB_ROUND_ROBIN_EN
    test_round_robin();
`else
    test_fixed_priority();
`endif
    cyc(2);
    monEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
